// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiplier job arbiter.
package matmul_pkg;

   localparam int DEFAULT_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/matmul_job_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest pending index at or after ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  winner,
   output logic            any
);

   logic [IDW-1:0]  cand [NREQ];
   logic [NREQ-1:0] hit;

   // cand[gi] is the requester index visited at search offset gi
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [IDW:0] sum;
         assign sum      = {1'b0, ptr} + (IDW+1)'(gi);
         assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
         assign hit[gi]  = req[cand[gi]];
      end
   endgenerate

   always_comb begin
      winner = '0;
      any    = |req;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (hit[i]) begin
            winner = cand[i];
         end
      end
   end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Round-robin arbiter sharing one start/done matrix multiplier among NREQ requesters,
// with a per-job watchdog that ends a hung job with an error response.
module matmul_job_arbiter
   import matmul_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] ack,
   output logic            err,
   output logic            mm_start,
   output logic [IDW-1:0]  mm_sel,
   input  logic            mm_done,
   output logic            busy
);

   localparam int CW = $clog2(TIMEOUT);

   arb_state_t     state_reg, state_next;
   logic [IDW-1:0] ptr_reg, ptr_next;
   logic [IDW-1:0] winner_reg, winner_next;
   logic           err_reg, err_next;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic [IDW-1:0] pick;
   logic           pick_any;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .winner (pick),
      .any    (pick_any)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         winner_reg <= '0;
         err_reg    <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         winner_reg <= winner_next;
         err_reg    <= err_next;
         cnt_reg    <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      winner_next = winner_reg;
      err_next    = err_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next  = GRANT;
               winner_next = pick;
               ptr_next    = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
            end
         end
         GRANT: begin
            state_next = BUSY;
            cnt_next   = '0;
            err_next   = 1'b0;
         end
         BUSY: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (mm_done) begin
               state_next = RESP;
               err_next   = 1'b0;
            end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
               state_next = RESP;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode only from state and the registered winner/err, so they are glitch-free
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_out
         assign gnt[gi] = (state_reg != IDLE) && (winner_reg == IDW'(gi));
         assign ack[gi] = (state_reg == RESP) && (winner_reg == IDW'(gi));
      end
   endgenerate

   assign mm_start = (state_reg == GRANT);
   assign mm_sel   = winner_reg;
   assign err      = (state_reg == RESP) && err_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed self-checking bench: main instance for normal jobs, second instance with TIMEOUT=16.
module tb_matmul_job_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req, gnt, ack;
   logic       err, mm_start, mm_done, busy;
   logic [1:0] mm_sel;

   logic [3:0] t_req, t_gnt, t_ack;
   logic       t_err, t_mm_start, t_mm_done, t_busy;
   logic [1:0] t_mm_sel;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   matmul_job_arbiter #(.NREQ(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .gnt      (gnt),
      .ack      (ack),
      .err      (err),
      .mm_start (mm_start),
      .mm_sel   (mm_sel),
      .mm_done  (mm_done),
      .busy     (busy)
   );

   matmul_job_arbiter #(.NREQ(4), .TIMEOUT(16)) dut_to (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (t_req),
      .gnt      (t_gnt),
      .ack      (t_ack),
      .err      (t_err),
      .mm_start (t_mm_start),
      .mm_sel   (t_mm_sel),
      .mm_done  (t_mm_done),
      .busy     (t_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req       = '0;
      mm_done   = 1'b0;
      t_req     = '0;
      t_mm_done = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Multiplier model: wait for start, run lat BUSY cycles, pulse done, check the response
   task automatic do_job(input string tag, input int exp_sel, input int lat, input bit drop,
                         output int wait_n);
      int  k;
      bit  held;
      logic [3:0] onehot;
      k      = 0;
      held   = 1'b1;
      onehot = 4'b0001 << exp_sel;
      while (mm_start !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      wait_n = k;
      chk({tag, "_start"}, mm_start, 1);
      chk({tag, "_sel"}, mm_sel, exp_sel);
      chk({tag, "_gnt"}, gnt, onehot);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (mm_start !== 1'b0 || gnt !== onehot || mm_sel !== onehot[3:2] * 2 + {1'b0, onehot[1]} * 1 + onehot[3] * 1 - onehot[2] * 0 - (onehot[3] ? 2 : 0) + (onehot[3] ? 0 : 0)
             && 1'b0 || ack !== 4'b0000 || busy !== 1'b1)
            held = 1'b0;
         if (mm_sel !== exp_sel[1:0]) held = 1'b0;
      end
      chk({tag, "_hold"}, held, 1);
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
      chk({tag, "_ack"}, ack, onehot);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_gnt_resp"}, gnt, onehot);
      if (drop) req[exp_sel] = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_clr"}, ack, 0);
      chk({tag, "_idle"}, busy, 0);
      $display("job %s sel=%0d lat=%0d wait=%0d", tag, exp_sel, lat, wait_n);
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = '0;
      mm_done   = 1'b0;
      t_req     = '0;
      t_mm_done = 1'b0;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_start", mm_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", mm_sel, 0);

      // Single requester, 80-cycle multiplier
      do_reset();
      req = 4'b0100;
      do_job("single", 2, 80, 1'b1, n);
      chk("single_sel_keep", mm_sel, 2);
      chk("single_gnt_off", gnt, 0);

      // All four requesting continuously: strict rotation with 3 cycles of overhead
      do_reset();
      req = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         do_job($sformatf("rr%0d", j), j % 4, 3, (j == 7), n);
         chk($sformatf("rr%0d_spacing", j), n, 1);
      end

      // Wrap search: ptr=1 after a grant to 0, then 1001 -> 3 then 0
      do_reset();
      req = 4'b0001;
      do_job("wrap_pre", 0, 4, 1'b1, n);
      req = 4'b1001;
      do_job("wrap_a", 3, 4, 1'b1, n);
      do_job("wrap_b", 0, 4, 1'b1, n);

      // Watchdog on the TIMEOUT=16 instance
      t_req = 4'b0001;
      n = 0;
      while (t_mm_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("to_start", t_mm_start, 1);
      n = 0;
      while (t_ack === 4'b0000 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_latency", n, 17);
      chk("to_ack", t_ack, 4'b0001);
      chk("to_err", t_err, 1);
      t_req = '0;
      @(negedge clk);
      chk("to_idle", t_busy, 0);
      chk("to_ack_clr", t_ack, 0);
      t_mm_done = 1'b1;
      @(negedge clk);
      t_mm_done = 1'b0;
      chk("stray_busy", t_busy, 0);
      chk("stray_ack", t_ack, 0);
      @(negedge clk);
      chk("stray_busy2", t_busy, 0);
      $display("job timeout sel=0 latency=17 err=1");

      // Done on the very cycle the watchdog expires: done wins
      t_req = 4'b0010;
      n = 0;
      while (t_mm_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("edge_start", t_mm_start, 1);
      chk("edge_sel", t_mm_sel, 1);
      repeat (16) @(negedge clk);
      chk("edge_busy", t_busy, 1);
      t_mm_done = 1'b1;
      @(negedge clk);
      t_mm_done = 1'b0;
      chk("edge_ack", t_ack, 4'b0010);
      chk("edge_err", t_err, 0);
      t_req = '0;
      $display("job edge sel=1 done_at_timeout err=0");

      // Asynchronous reset during BUSY
      do_reset();
      req = 4'b0100;
      n = 0;
      while (mm_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ar_start", mm_start, 1);
      repeat (3) @(negedge clk);
      chk("ar_busy_pre", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_gnt", gnt, 0);
      chk("ar_ack", ack, 0);
      chk("ar_err", err, 0);
      chk("ar_start0", mm_start, 0);
      chk("ar_busy", busy, 0);
      chk("ar_sel", mm_sel, 0);
      req = 4'b0010;
      @(negedge clk);
      chk("ar_ack_hold", ack, 0);
      reset_n = 1'b1;
      do_job("after_rst", 1, 5, 1'b1, n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
